// File: rtl/mult_share_arb.sv
// Round-robin sharing of one radix-4 Booth 16x16 multiplier among NREQ requesters.
// Two-stage pipeline: S1 holds granted operands, S2 holds the registered product.

module rad4_exact_mult (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);

  logic [31:0] xs;
  logic [16:0] y_ext;
  logic [31:0] pp [8];

  assign xs    = {{16{x[15]}}, x};
  assign y_ext = {y, 1'b0};

  // Each overlapping bit triplet of y selects a digit in {-2,-1,0,+1,+2}.
  for (genvar g = 0; g < 8; g++) begin : g_pp
    logic [2:0]  trip;
    logic [31:0] mag;

    assign trip = y_ext[2*g +: 3];

    always_comb begin
      case (trip)
        3'b001, 3'b010: mag = xs;
        3'b011:         mag = xs << 1;
        3'b100:         mag = -(xs << 1);
        3'b101, 3'b110: mag = -xs;
        default:        mag = '0;
      endcase
    end

    assign pp[g] = mag << (2*g);
  end

  assign p = pp[0] + pp[1] + pp[2] + pp[3] + pp[4] + pp[5] + pp[6] + pp[7];

endmodule

module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [16*NREQ-1:0] req_x,
  input  logic [16*NREQ-1:0] req_y,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_p,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy
);

  logic [15:0]     x_q, y_q;
  logic [IDW-1:0]  id1, id2;
  logic            v1, v2;
  logic [31:0]     p_q;
  logic [31:0]     core_p;
  logic [IDW-1:0]  rr;

  logic            adv;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;
  logic            accept;
  logic [IDW-1:0]  rr_next;

  rad4_exact_mult u_core (
    .x (x_q),
    .y (y_q),
    .p (core_p)
  );

  assign adv = !v2 || rsp_ready;

  // Search from rr upward, wrapping at NREQ; the first pending requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_any && req_valid[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  assign accept    = rst_n && adv && grant_any;
  assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
  assign rr_next   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

  // Both stages move together; a stalled S2 freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      id1 <= '0;
      v1  <= 1'b0;
      p_q <= '0;
      id2 <= '0;
      v2  <= 1'b0;
      rr  <= '0;
    end else if (adv) begin
      p_q <= core_p;
      id2 <= id1;
      v2  <= v1;
      if (accept) begin
        x_q <= req_x[{grant_idx, 4'd0} +: 16];
        y_q <= req_y[{grant_idx, 4'd0} +: 16];
        id1 <= grant_idx;
        v1  <= 1'b1;
        rr  <= rr_next;
      end else begin
        v1  <= 1'b0;
      end
    end
  end

  assign rsp_valid = v2;
  assign rsp_p     = p_q;
  assign rsp_id    = id2;
  assign busy      = v1 || v2;

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: queue-based reference model checked
// every cycle, plus directed literal expectations and a randomized phase.

module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_x;
  logic [16*NREQ-1:0] req_y;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_p;
  logic [IDW-1:0]     rsp_id;
  logic               busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [31:0] p;
    bit          at_out;
  } entry_t;

  entry_t      pipe[$];
  int          m_rr;
  int          seen_id[$];
  logic [31:0] seen_p[$];

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Reference model: in-flight entries in acceptance order; the head is visible
  // once it has spent one edge in the pipe.
  initial begin
    int          exp_gnt;
    bit          m_adv;
    bit          exp_rv;
    logic [31:0] exp_ready;
    m_rr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pipe.delete();
        m_rr = 0;
      end
      exp_rv  = rst_n && pipe.size() > 0 && pipe[0].at_out;
      m_adv   = !exp_rv || rsp_ready;
      exp_gnt = -1;
      if (rst_n && m_adv) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_rr + k) % NREQ;
          if (exp_gnt < 0 && req_valid[idx]) exp_gnt = idx;
        end
      end
      exp_ready = (exp_gnt >= 0) ? (32'd1 << exp_gnt) : 32'd0;
      check_output("req_ready", 32'(req_ready), exp_ready);
      check_output("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check_output("busy", 32'(busy), 32'(rst_n && pipe.size() > 0));
      if (exp_rv) begin
        check_output("rsp_p", rsp_p, pipe[0].p);
        check_output("rsp_id", 32'(rsp_id), 32'(pipe[0].id));
      end
      @(posedge clk);
      if (rst_n && m_adv) begin
        if (exp_rv) begin
          seen_id.push_back(pipe[0].id);
          seen_p.push_back(pipe[0].p);
          void'(pipe.pop_front());
        end
        foreach (pipe[j]) pipe[j].at_out = 1'b1;
        if (exp_gnt >= 0) begin
          entry_t e;
          e.id     = exp_gnt;
          e.p      = ref_mult(req_x[16*exp_gnt +: 16], req_y[16*exp_gnt +: 16]);
          e.at_out = 1'b0;
          pipe.push_back(e);
          m_rr = (exp_gnt + 1) % NREQ;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic [15:0] x0,
                                input logic [15:0] y_base, input logic rdy);
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_x[16*i +: 16] = x0;
      req_y[16*i +: 16] = y_base + 16'(i);
    end
    rsp_ready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen_id.delete();
    seen_p.delete();
  endtask

  initial begin
    logic [NREQ-1:0] acc;
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;

    // Reset values
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #1;
      check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_req_ready", 32'(req_ready), 32'd0);
      check_output("reset_rsp_p", rsp_p, 32'd0);
      check_output("reset_rsp_id", 32'(rsp_id), 32'd0);
      tick();
    end

    // Single multiply from requester 2
    req_valid = 4'b0100;
    req_x[32 +: 16] = 16'd1234;
    req_y[32 +: 16] = 16'd5678;
    #1;
    check_output("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    #1;
    check_output("single_valid", 32'(rsp_valid), 32'd1);
    check_output("single_p", rsp_p, 32'h006AE9BC);
    check_output("single_id", 32'(rsp_id), 32'd2);
    tick();
    #1;
    check_output("single_once", 32'(rsp_valid), 32'd0);

    // Full contention: rotation 0,1,2,3 from a fresh pointer
    do_reset();
    apply_stimulus(4'b1111, 16'h7FFF, 16'd1, 1'b1);
    repeat (12) tick();
    req_valid = '0;
    repeat (4) tick();
    check_output("contention_count", 32'(seen_id.size() >= 8), 32'd1);
    for (int k = 0; k < 8 && k < seen_id.size(); k++) begin
      check_output("contention_id", 32'(seen_id[k]), 32'(k % NREQ));
      check_output("contention_p", seen_p[k], 32'h7FFF * 32'(k % NREQ + 1));
    end
    if (seen_p.size() > 2) check_output("contention_p_id2", seen_p[2], 32'h00017FFD);

    // Backpressure in the middle of a full-rate stream
    do_reset();
    apply_stimulus(4'b1111, 16'h1357, 16'd3, 1'b1);
    repeat (4) tick();
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_output("stall_valid", 32'(rsp_valid), 32'd1);
      check_output("stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    repeat (12) tick();
    req_valid = '0;
    repeat (4) tick();
    check_output("bp_count", 32'(seen_id.size() >= 16), 32'd1);
    for (int k = 0; k < 16 && k < seen_id.size(); k++)
      check_output("bp_order", 32'(seen_id[k]), 32'(k % NREQ));

    // Pointer wrap: steer rr to 3, then only requesters 3 and 0 compete
    do_reset();
    apply_stimulus(4'b0100, 16'h7FFF, 16'h7FFF, 1'b1);
    tick();
    apply_stimulus(4'b1001, 16'h7FFF, 16'h7FFF, 1'b1);
    for (int i = 0; i < NREQ; i++) req_y[16*i +: 16] = 16'h7FFF;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_output("wrap_grant", 32'(req_ready), (c % 2 == 0) ? 32'h8 : 32'h1);
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    if (seen_p.size() > 1) check_output("wrap_p", seen_p[1], 32'h3FFF0001);
    else check_output("wrap_count", 32'(seen_p.size()), 32'd5);

    // Reset pulse while both stages are occupied
    do_reset();
    apply_stimulus(4'b1111, 16'h00A5, 16'd7, 1'b0);
    repeat (3) tick();
    #1;
    check_output("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("mid_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    seen_id.delete();
    seen_p.delete();
    apply_stimulus(4'b0110, 16'h00A5, 16'd7, 1'b1);
    #1;
    check_output("mid_first_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    repeat (3) tick();
    if (seen_id.size() > 0) check_output("mid_first_rsp", 32'(seen_id[0]), 32'd1);
    else check_output("mid_rsp_count", 32'(seen_id.size()), 32'd1);

    // Randomized traffic honouring the hold-until-accepted rule
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i]      = ($urandom_range(0, 9) < 6);
          req_x[16*i +: 16] = 16'($urandom);
          req_y[16*i +: 16] = 16'($urandom);
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    #1;
    check_output("drain_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that shares one `rad4_exact_mult` 16x16 multiplier core among `NREQ` requesters. Each requester offers operands through a valid/ready handshake. The block registers the granted operands, drives them through the core, and registers the 32-bit product. The product is returned with the winning requester's index. The pipeline sustains one multiply per cycle and fully stalls under response backpressure.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `IDW`, default 2: width of the requester index, equal to clog2(`NREQ`).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  `NREQ`: requester i has operands pending.
- `req_x`  in  16*`NREQ`: multiplicand; requester i owns bits [16i+15:16i].
- `req_y`  in  16*`NREQ`: multiplier; same packing as `req_x`.
- `req_ready`  out  `NREQ`: one-hot or zero; bit i high means requester i is accepted this cycle.
- `rsp_valid`  out  1: `rsp_p` and `rsp_id` are valid.
- `rsp_ready`  in  1: the consumer takes the response this cycle.
- `rsp_p`  out  32: product, exactly as produced by `rad4_exact_mult`.
- `rsp_id`  out  `IDW`: index of the requester that owns `rsp_p`.
- `busy`  out  1: high when either pipeline stage holds a valid entry.

## Operation
- **Stage S1 registers:** `x_q`, `y_q`, `id1`, `v1`. These are the operand registers that feed the combinational `rad4_exact_mult`.
- **Stage S2 registers:** `p_q`, `id2`, `v2`. These drive `rsp_p`, `rsp_id` and `rsp_valid` directly.
- **Advance condition:** `adv = !v2 | rsp_ready`.
- **When `adv` is high:**
  - S2 loads from S1: `p_q` <= core output, `id2` <= `id1`, `v2` <= `v1`.
  - S1 loads the granted request, or clears `v1` if there is no grant.
- **When `adv` is low:** S1 and S2 hold all their contents, and `req_ready` is all-zero.
- **Arbitration:** combinational and round-robin.
  - Search `req_valid` starting at pointer `rr` and wrapping modulo `NREQ`.
  - The first set bit i wins, but only if `adv` is high.
  - `req_ready` = one-hot(i) & {`NREQ`{`adv`}}.
- **Pointer update:** on an accept by requester i, `rr` <= (i+1) mod `NREQ`. With no accept, `rr` holds.
- **Operand transfer:** operands are forwarded unmodified. The block adds no sign handling; signedness is defined solely by the core.
- **Response ordering:** responses return in acceptance order. There is no reordering and no dropping.
- **Requester obligations:**
  - Requesters must hold `req_x`, `req_y` and `req_valid` stable until accepted.
  - `req_ready` may depend on `req_valid`.
  - `rsp_valid` never depends on `rsp_ready`.
- **Reset values:**
  - `v1` = `v2` = 0, so `rsp_valid` = 0 and `busy` = 0.
  - `rsp_p` = 0, `rsp_id` = 0, `rr` = 0.
  - `req_ready` = 0 while `rst_n` is low.
- **Reset mid-operation:** asserting `rst_n` low discards any in-flight entries immediately, with no responses emitted. After reset, arbitration restarts at requester 0.

## Timing
- **Latency:** an accept at rising edge N, meaning `req_valid[i]` and `req_ready[i]` were both high in the preceding cycle, produces `rsp_valid` = 1 after edge N+1.
  - Only if `adv` stays high across that edge.
  - That response is first consumable at edge N+2.
- **Throughput:** one accept per cycle whenever `rsp_ready` = 1 or S2 is empty.
- **Stall:** when `rsp_valid` = 1 and `rsp_ready` = 0, nothing moves and no new accepts occur.
  - Capacity is 2 entries, one in S1 and one in S2.
  - The cycle after `rsp_ready` rises, flow resumes at full rate with no bubble.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,...,`NREQ`-1,0 with no starvation. The worst-case wait is `NREQ`-1 accepts.
- **Boundary events:**
  - *Single requester continuously valid:* it wins every cycle.
  - *Grant at i = `NREQ`-1:* `rr` wraps to 0.
  - *Accept and response in the same cycle:* both occur; S2 is replaced at the same edge it is consumed.
  - *Requester drops `req_valid` while not granted:* legal, no effect.

## Test plan
- **Reset values:** hold `rst_n` low for 3 cycles, then release with all `req_valid` = 0.
  - Required: `rsp_valid` = 0, `busy` = 0, `req_ready` = 0 for 5 cycles.
- **Single multiply:** requester 2 drives x = 1234, y = 5678 with `rsp_ready` = 1.
  - Required: `req_ready[2]` = 1 in that cycle.
  - Required: 2 edges later, `rsp_valid` = 1, `rsp_p` = 0x006AE9BC, `rsp_id` = 2, for exactly one cycle.
- **Full contention:** all 4 requesters continuously valid, requester i driving x = 0x7FFF, y = i+1.
  - Required: `rsp_id` sequence 0,1,2,3,0,1,... at one response per cycle.
  - Required: `rsp_p` = 0x7FFF*(id+1), e.g. 0x00017FFD for id = 2.
- **Backpressure:** during a full-rate stream, hold `rsp_ready` = 0 for 4 cycles.
  - Required: `rsp_valid`, `rsp_p` and `rsp_id` remain stable throughout.
  - Required: `req_ready` = 0 after the pipeline fills.
  - Required: after release, every response arrives in order with none lost or duplicated.
- **Pointer wrap:** only requesters 3 and 0 valid, starting from `rr` = 3.
  - Required: grants alternate 3,0,3,0.
  - Required: x = 0x7FFF, y = 0x7FFF returns 0x3FFF0001.
- **Reset mid-flight:** pulse `rst_n` low for 1 cycle while both stages are valid.
  - Required: `rsp_valid` falls immediately (asynchronously) and no stale response appears.
  - Required: the next accept goes to the lowest-index valid requester.
